// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the helper that sizes the load-latency countdown.
package pipe_pkg;

  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;
  localparam logic [2:0] MEM_LOAD_NONE = 3'b000;

  // Countdown width must hold LOAD_LAT-1; never narrower than one bit.
  function automatic int lat_w(input int load_lat);
    return (load_lat <= 2) ? 1 : $clog2(load_lat);
  endfunction

endpackage

// File: rtl/ld_scoreboard.sv
// Per-register load countdown: youngest live write sets the entry, otherwise it
// counts down to zero. Answers "pending?" for a vector of source addresses.
module ld_scoreboard
  import pipe_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int LOAD_LAT = 2,
  parameter int NQ       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       live_write_i,
  input  logic [LANES-1:0]       live_load_i,
  input  logic [LANES*REG_W-1:0] rd_i,
  input  logic [NQ*REG_W-1:0]    q_addr_i,
  output logic [NQ-1:0]          pend_o
);

  localparam int LW = lat_w(LOAD_LAT);
  localparam logic [LW-1:0] LAT_M1 = LW'(LOAD_LAT - 1);
  localparam logic [LW-1:0] ONE    = LW'(1);

  logic [LW-1:0]       cnt_q [NUM_REGS];
  logic [LW-1:0]       cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] e_hit;

  always_comb begin
    e_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - ONE) : cnt_q[r];
    end
    // Ascending lane order lets the youngest lane override older ones.
    for (int i = 0; i < LANES; i++) begin
      if (live_write_i[i]) begin
        cnt_d[rd_i[i*REG_W +: REG_W]] = live_load_i[i] ? LAT_M1 : '0;
        if (live_load_i[i]) e_hit[rd_i[i*REG_W +: REG_W]] = 1'b1;
      end
    end
    cnt_d[0] = '0;
    e_hit[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    pend_o = '0;
    for (int q = 0; q < NQ; q++) begin
      pend_o[q] = (q_addr_i[q*REG_W +: REG_W] != '0) &&
                  (e_hit[q_addr_i[q*REG_W +: REG_W]] ||
                   (cnt_q[q_addr_i[q*REG_W +: REG_W]] != '0));
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit between decode and execute: global decode stall plus a
// saturating stall-cycle counter.
module load_use_scoreboard
  import pipe_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       validD,
  input  logic [LANES*REG_W-1:0] rs1D,
  input  logic [LANES*REG_W-1:0] rs2D,
  input  logic [LANES-1:0]       validE,
  input  logic [LANES*REG_W-1:0] rdE,
  input  logic [LANES-1:0]       reg_writeE,
  input  logic [LANES*3-1:0]     mem_loadE,
  input  logic                   flushE,
  output logic                   stall,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int NQ = 2 * LANES;

  logic [LANES-1:0]    live_write;
  logic [LANES-1:0]    live_load;
  logic [NQ-1:0]       pend;
  logic [CNT_W-1:0]    stall_cycles_q;
  logic [CNT_W-1:0]    stall_cycles_d;

  always_comb begin
    live_write = '0;
    live_load  = '0;
    for (int i = 0; i < LANES; i++) begin
      live_write[i] = validE[i] && reg_writeE[i] && !flushE &&
                      (rdE[i*REG_W +: REG_W] != '0);
      live_load[i]  = live_write[i] && (mem_loadE[i*3 +: 3] != MEM_LOAD_NONE);
    end
  end

  // Queries 0..LANES-1 are rs1 per lane, LANES..2*LANES-1 are rs2.
  ld_scoreboard #(
    .LANES   (LANES),
    .LOAD_LAT(LOAD_LAT),
    .NQ      (NQ)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .live_write_i(live_write),
    .live_load_i (live_load),
    .rd_i        (rdE),
    .q_addr_i    ({rs2D, rs1D}),
    .pend_o      (pend)
  );

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (validD[i] && (pend[i] || pend[LANES+i])) stall = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Scoreboard bench: per-register "forwardable from cycle N" reference model,
// directed hazard scenarios followed by random traffic.
module tb_load_use_scoreboard;

  localparam int LANES    = 2;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  validD;
  logic [9:0]  rs1D, rs2D;
  logic [1:0]  validE;
  logic [9:0]  rdE;
  logic [1:0]  reg_writeE;
  logic [5:0]  mem_loadE;
  logic        flushE;
  logic        stall;
  logic [3:0]  stall_cycles;

  always #5 clk = ~clk;

  load_use_scoreboard #(
    .LANES(LANES), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .validE(validE), .rdE(rdE), .reg_writeE(reg_writeE),
    .mem_loadE(mem_loadE), .flushE(flushE),
    .stall(stall), .stall_cycles(stall_cycles)
  );

  // Reference model: register r is unreadable until cycle avail[r].
  int          avail [32];
  int          cyc;
  int          exp_cnt;
  logic [4:0]  exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic bit e_load_to(input int r);
    bit hit = 0;
    for (int i = 0; i < LANES; i++) begin
      if (validE[i] && reg_writeE[i] && !flushE && mem_loadE[i*3 +: 3] != 3'b000 &&
          int'(rdE[i*5 +: 5]) == r && r != 0) hit = 1;
    end
    return hit;
  endfunction

  function automatic bit pend_m(input int r);
    if (r == 0) return 0;
    return e_load_to(r) || (avail[r] > cyc);
  endfunction

  task automatic step(input logic [1:0] vD, input logic [9:0] r1, input logic [9:0] r2,
                      input logic [1:0] vE, input logic [9:0] rd, input logic [1:0] rw,
                      input logic [5:0] ml, input logic fl, input logic rst);
    bit es;
    validD = vD; rs1D = r1; rs2D = r2; validE = vE; rdE = rd;
    reg_writeE = rw; mem_loadE = ml; flushE = fl; reset = rst;
    es = 0;
    for (int i = 0; i < LANES; i++) begin
      if (vD[i] && (pend_m(int'(r1[i*5 +: 5])) || pend_m(int'(r2[i*5 +: 5])))) es = 1;
    end
    exp_q.push_back({es, 4'(exp_cnt)});
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) avail[r] = 0;
      exp_cnt = 0;
    end else begin
      if (es && exp_cnt < CNT_MAX) exp_cnt++;
      for (int i = 0; i < LANES; i++) begin
        if (vE[i] && rw[i] && !fl && rd[i*5 +: 5] != 5'd0)
          avail[rd[i*5 +: 5]] = (ml[i*3 +: 3] != 3'b000) ? cyc + LOAD_LAT : cyc;
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic [9:0] p2(input int l0, input int l1);
    return {5'(l1), 5'(l0)};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (stall === e[4]) n_pass++;
      else $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, e[4]);
      n_checks++;
      if (stall_cycles === e[3:0]) n_pass++;
      else $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", cyc, stall_cycles, e[3:0]);
    end
  end

  initial begin
    validD = '0; rs1D = '0; rs2D = '0; validE = '0; rdE = '0;
    reg_writeE = '0; mem_loadE = '0; flushE = 1'b0; reset = 1'b1;
    cyc = 0; exp_cnt = 0;
    for (int r = 0; r < 32; r++) avail[r] = 0;
    repeat (2) @(posedge clk);
    #1;
    step(2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);

    // Load to x5 on lane0 with a lane1 reader of x5 in the same cycle.
    step(2'b10, p2(0,0), p2(0,5), 2'b01, p2(5,0), 2'b01, 6'b000_010, 0, 0);
    // Load to x7, then read x7 four cycles in a row.
    step(2'b01, p2(7,0), 0, 2'b01, p2(7,0), 2'b01, 6'b000_010, 0, 0);
    for (int k = 0; k < 3; k++) step(2'b01, p2(7,0), 0, 2'b00, 0, 2'b00, 0, 0, 0);
    // Load x7 then a younger ALU write to x7: reader two cycles later is free.
    step(2'b00, 0, 0, 2'b01, p2(7,0), 2'b01, 6'b000_010, 0, 0);
    step(2'b00, 0, 0, 2'b01, p2(7,0), 2'b01, 6'b000_000, 0, 0);
    step(2'b01, p2(7,0), 0, 2'b00, 0, 2'b00, 0, 0, 0);
    // Same-cycle load+ALU to x4, both lane orders.
    step(2'b00, 0, 0, 2'b11, p2(4,4), 2'b11, 6'b000_010, 0, 0);
    step(2'b01, 0, p2(4,0), 2'b00, 0, 2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 2'b11, p2(4,4), 2'b11, 6'b010_000, 0, 0);
    step(2'b01, 0, p2(4,0), 2'b00, 0, 2'b00, 0, 0, 0);
    step(2'b01, 0, p2(4,0), 2'b00, 0, 2'b00, 0, 0, 0);
    step(2'b01, 0, p2(4,0), 2'b00, 0, 2'b00, 0, 0, 0);
    // x0 load, invalid reader lane, flushed load to x9.
    step(2'b01, 0, 0, 2'b01, 0, 2'b01, 6'b000_010, 0, 0);
    step(2'b10, p2(9,0), 0, 2'b01, p2(9,0), 2'b01, 6'b000_010, 0, 0);
    step(2'b01, p2(9,0), 0, 2'b01, p2(9,0), 2'b01, 6'b000_010, 1, 0);
    step(2'b01, p2(9,0), p2(9,0), 2'b00, 0, 2'b00, 0, 0, 0);
    // Reset mid-countdown on x3.
    step(2'b00, 0, 0, 2'b01, p2(3,0), 2'b01, 6'b000_100, 0, 0);
    step(2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1);
    step(2'b01, p2(3,0), 0, 2'b00, 0, 2'b00, 0, 0, 0);
    // Saturation of the 4-bit counter.
    for (int k = 0; k < 20; k++) step(2'b11, p2(6,6), 0, 2'b10, p2(0,6), 2'b10, 6'b001_000, 0, 0);
    step(2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
    step(2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0, 1);

    for (int k = 0; k < 400; k++) begin
      logic [9:0] r1, r2, rd;
      logic [5:0] ml;
      r1 = p2($urandom_range(0,7), $urandom_range(0,7));
      r2 = p2($urandom_range(0,7), $urandom_range(0,7));
      rd = p2($urandom_range(0,7), $urandom_range(0,7));
      ml = 6'($urandom);
      if ($urandom_range(0,1) == 0) ml[2:0] = 3'b000;
      if ($urandom_range(0,1) == 0) ml[5:3] = 3'b000;
      step(2'($urandom), r1, r2, 2'($urandom), rd, 2'($urandom), ml,
           ($urandom_range(0,9) == 0), ($urandom_range(0,59) == 0));
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
